// File: rtl/render_pkg.sv
// Shared rendering types: triangle packing and dispatch sequencer states.
`default_nettype none

package render_pkg;

   localparam int COORD_W = 32;
   localparam int TRI_W   = 288;

   // Declared z,y,x so that x lands in the low bits of each vertex.
   typedef struct packed {
      logic [COORD_W-1:0] z;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } vertex_t;

   typedef vertex_t [2:0] triangle_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      ISSUE   = 3'd2,
      WAIT    = 3'd3,
      ADVANCE = 3'd4,
      DONE    = 3'd5
   } dispatch_state_t;

endpackage

`default_nettype wire

// File: rtl/shader_dispatch_if.sv
// Frame control, triangle BRAM read port and shader handshake of the dispatcher.
`default_nettype none

interface shader_dispatch_if #(
   parameter int ADDR_W = 10
);
   import render_pkg::*;

   logic              frame_start_in;
   logic [ADDR_W:0]   num_tris_in;
   logic [ADDR_W-1:0] mem_addr_out;
   triangle_t         mem_data_in;
   logic              shader_valid_out;
   triangle_t         shader_tri_out;
   logic              shader_done_in;
   logic              busy_out;
   logic              frame_done_out;
   logic [ADDR_W:0]   tri_count_out;
   logic              timeout_err_out;

   modport master (
      input  frame_start_in, num_tris_in, mem_data_in, shader_done_in,
      output mem_addr_out, shader_valid_out, shader_tri_out, busy_out,
             frame_done_out, tri_count_out, timeout_err_out
   );

   modport slave (
      output frame_start_in, num_tris_in, mem_data_in, shader_done_in,
      input  mem_addr_out, shader_valid_out, shader_tri_out, busy_out,
             frame_done_out, tri_count_out, timeout_err_out
   );

endinterface

`default_nettype wire

// File: rtl/shader_dispatch.sv
// Per-frame sequencer: walks the triangle BRAM and hands one triangle at a
// time to pixel_shader, with a per-triangle watchdog and completion count.
`default_nettype none

module shader_dispatch
   import render_pkg::*;
#(
   parameter int MAX_TRIS    = 1024,
   parameter int ADDR_W      = $clog2(MAX_TRIS),
   parameter int MEM_LATENCY = 2,
   parameter int TIMEOUT     = 4096
) (
   input wire logic          clk_in,
   input wire logic          rst_in,
   shader_dispatch_if.master bus
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int LAT_W = $clog2(MEM_LATENCY + 2);
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_TRIS);

   dispatch_state_t  state;
   dispatch_state_t  next_state;
   logic [CNT_W-1:0] num_tris;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] next_idx;
   logic [CNT_W-1:0] sat_n;
   logic [LAT_W-1:0] lat_cnt;
   logic [WD_W-1:0]  wd_cnt;
   logic             fetch_ready;
   logic             wd_expired;
   logic             last_tri;

   assign sat_n       = (bus.num_tris_in > MAX_N) ? MAX_N : bus.num_tris_in;
   assign next_idx    = idx + 1'b1;
   assign fetch_ready = (lat_cnt == LAT_W'(MEM_LATENCY));
   assign wd_expired  = (wd_cnt == WD_W'(TIMEOUT - 1));
   assign last_tri    = (next_idx == num_tris);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.frame_start_in) begin
               next_state = (sat_n == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (fetch_ready) begin
               next_state = ISSUE;
            end
         end
         ISSUE:   next_state = WAIT;
         WAIT: begin
            if (bus.shader_done_in || wd_expired) begin
               next_state = ADVANCE;
            end
         end
         ADVANCE: next_state = last_tri ? DONE : FETCH;
         // DONE spans two cycles: the first registers the pulse, the second shows it.
         DONE: begin
            if (bus.frame_done_out) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.busy_out = (state != IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         num_tris             <= '0;
         idx                  <= '0;
         lat_cnt              <= '0;
         wd_cnt               <= '0;
         bus.mem_addr_out     <= '0;
         bus.shader_valid_out <= 1'b0;
         bus.shader_tri_out   <= '0;
         bus.frame_done_out   <= 1'b0;
         bus.tri_count_out    <= '0;
         bus.timeout_err_out  <= 1'b0;
      end else begin
         bus.shader_valid_out <= 1'b0;
         bus.frame_done_out   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.frame_start_in) begin
                  num_tris            <= sat_n;
                  idx                 <= '0;
                  lat_cnt             <= '0;
                  bus.mem_addr_out    <= '0;
                  bus.tri_count_out   <= '0;
                  bus.timeout_err_out <= 1'b0;
               end
            end
            FETCH: begin
               if (fetch_ready) begin
                  bus.shader_tri_out   <= bus.mem_data_in;
                  bus.shader_valid_out <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            ISSUE: begin
               wd_cnt <= '0;
            end
            WAIT: begin
               // A done arriving on the terminal watchdog cycle still counts.
               if (bus.shader_done_in) begin
                  bus.tri_count_out <= bus.tri_count_out + 1'b1;
               end else if (wd_expired) begin
                  bus.timeout_err_out <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            ADVANCE: begin
               idx     <= next_idx;
               lat_cnt <= '0;
               if (!last_tri) begin
                  bus.mem_addr_out <= ADDR_W'(next_idx);
               end
            end
            DONE: begin
               if (!bus.frame_done_out) begin
                  bus.frame_done_out <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/shader_dispatch.md
Name: shader_dispatch

Overview:
- Per-frame sequencer for pixel_shader.
- On frame start, walks a triangle list held in a synchronous BRAM.
- Presents one triangle at a time to the shader with a single-cycle valid pulse, then waits for the shader's valid_out before fetching the next.
- Counts completed triangles, flags shader stalls via a watchdog, and signals frame completion to the frame-buffer swap logic.

Parameters:
- MAX_TRIS, 1024, capacity of the triangle BRAM.
- ADDR_W, $clog2(MAX_TRIS), BRAM address width.
- MEM_LATENCY, 2, BRAM read latency in cycles, from address to data valid.
- TIMEOUT, 4096, cycles allowed in WAIT before a triangle is abandoned.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- frame_start_in  input  1  single-cycle request to render one frame
- num_tris_in  input  ADDR_W+1  triangle count, sampled with frame_start_in
- mem_addr_out  output  ADDR_W  BRAM read address
- mem_data_in  input  288  BRAM read data: 3 vertices x (x,y,z) x 32 bits; vertex0.x in bits [31:0]
- shader_valid_out  output  1  triangle valid pulse to the shader
- shader_tri_out  output  288  latched triangle, same packing as mem_data_in
- shader_done_in  input  1  shader valid_out
- busy_out  output  1  high in any state other than IDLE
- frame_done_out  output  1  single-cycle pulse at end of frame
- tri_count_out  output  ADDR_W+1  triangles completed in the current/last frame
- timeout_err_out  output  1  sticky; at least one triangle timed out this frame

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset mid-frame abandons the frame with no frame_done_out pulse.
- States and transitions:
  - IDLE: on frame_start_in, latch num_tris_in (N), clear tri_count_out and timeout_err_out, idx=0. Go to FETCH if N>0, else DONE. frame_start_in in any other state is ignored.
  - FETCH: mem_addr_out=idx, held stable. Wait MEM_LATENCY cycles, capture mem_data_in into shader_tri_out, then go to ISSUE.
  - ISSUE: shader_valid_out=1 for exactly this one cycle, then go to WAIT. shader_tri_out stays stable until the next capture.
  - WAIT: watchdog counts from 0.
    - shader_done_in=1: tri_count_out++, go to ADVANCE.
    - Watchdog reaches TIMEOUT-1 without done: set timeout_err_out, go to ADVANCE with no count increment.
    - Done and timeout in the same cycle: done wins.
  - ADVANCE: idx++. If idx==N go to DONE, else FETCH.
  - DONE: frame_done_out=1 for one cycle, then go to IDLE.
- Latency:
  - frame_start at cycle 0 -> FETCH at cycle 1.
  - First shader_valid_out at cycle 1+MEM_LATENCY+1.
  - With zero-latency shader response, throughput is one triangle per MEM_LATENCY+4 cycles.
- shader_done_in outside WAIT (stale or late) is ignored and not counted.
- N > MAX_TRIS is saturated to MAX_TRIS. idx never wraps.
- tri_count_out and timeout_err_out hold their values after DONE until the next accepted frame_start_in.
- busy_out is combinationally derived from state. All other outputs are registered.

Decomposition:
- Shared package render_pkg:
  - COORD_W=32, TRI_W=288.
  - typedefs vertex_t (x,y,z) and triangle_t (vertex_t [2:0]).
  - Dispatch state enum {IDLE, FETCH, ISSUE, WAIT, ADVANCE, DONE}.
  - pixel_shader and the BRAM wrapper adopt triangle_t.
- Single flat module. Latency and watchdog counters are small enough to keep inline; no sub-module.

Test Plan:
- N=3; BRAM holds triangles T0..T2; shader model answers 5 cycles after each valid -> three valid pulses carrying T0,T1,T2 in order, tri_count_out=3, one frame_done_out pulse, timeout_err_out=0.
- N=0 -> frame_done_out pulses at cycle 2; shader_valid_out never asserts; busy_out high for cycles 1-2 only.
- N=2; shader never answers triangle 0 -> timeout_err_out sets after TIMEOUT cycles in WAIT, triangle 1 still issued and answered, final tri_count_out=1.
- Second frame_start_in mid-frame plus a spurious shader_done_in during FETCH -> both ignored; original frame completes with the correct count.
- rst_in asserted during WAIT of triangle 1 of 4 -> next cycle all outputs 0, state IDLE, no frame_done_out. A new frame_start_in with N=1 then completes normally.
- shader_done_in coincides with the watchdog terminal cycle -> triangle counted, timeout_err_out stays 0.
